vga_pattern_sched: RTL and testbench
====================================

Name: vga_pattern_sched

Overview:
- Frame-synchronous controller that sequences test patterns for the 1920x1080 pixel generator.
- Selects the active pattern, checker cell size and foreground/background colours, in auto (timed) or manual (button-step) mode.
- Configuration outputs change only on the frame-start pulse from the timing generator, so a pattern switch never tears mid-frame.
- Sits between the board buttons/timing counters and the pixel-colour stage.

Parameters:
- FRAMES_PER_PAT, 60: frames each pattern is shown in auto mode (≥1).
- NUM_PAT, 5: number of patterns; pat_sel wraps NUM_PAT-1 -> 0 (2..8).
- DEB_CYCLES, 1485000: clk cycles a button must be stable to register (10 ms at 148.5 MHz); benches override to a small value.
- CHK_MIN, 5: smallest checker bit index.
- CHK_MAX, 8: largest checker bit index.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse on the last pixel of a frame (hcount=2199, vcount=1124).
- btn_next  in  1  raw asynchronous push button: step pattern.
- btn_mode  in  1  raw asynchronous push button: toggle auto/manual.
- pat_sel  out  3  active pattern index.
- chk_shift  out  4  checker bit index; the pixel stage XORs hcount[chk_shift] with vcount[chk_shift].
- fg_rgb  out  12  foreground colour {r,g,b}, 4 bits each.
- bg_rgb  out  12  background colour.
- auto_mode  out  1  1 = auto sequencing, 0 = manual.
- cfg_update  out  1  one-cycle pulse on the cycle after a commit that changed pat_sel or chk_shift.

Behaviour:
- **Reset** (rst=1 at a clk edge), all registered:
  - pat_sel=0, chk_shift=CHK_MAX, fg_rgb=12'hFFF, bg_rgb=12'h000, auto_mode=1, cfg_update=0.
  - Frame counter=0; pending_step=0; debouncers cleared, with the stable value 0.
  - Reset mid-frame discards any pending step.
- **Debounce, per button:**
  - 2-FF synchroniser, then a counter.
  - The counter resets whenever the synchronised value equals the stable value; otherwise it increments.
  - When it reaches DEB_CYCLES-1, the stable value takes the synchronised value.
  - A stable 0->1 transition produces a one-cycle press pulse.
  - Latency from raw edge to press pulse = 2 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES produce no pulse.
- **State machine** (AUTO, MANUAL):
  - mode press toggles the state on the next edge. auto_mode reflects the state immediately, not frame-gated.
  - Entering AUTO clears the frame counter and pending_step.
  - Entering MANUAL keeps the current pattern.
- **AUTO:**
  - Each frame_start increments the frame counter.
  - At frame_start with counter=FRAMES_PER_PAT-1: counter -> 0 and the pattern advances.
  - next presses are ignored.
- **MANUAL:**
  - A next press sets pending_step.
  - At frame_start with pending_step=1: the pattern advances and pending_step clears.
  - Multiple presses within one frame collapse to one step.
  - A press on the same cycle as frame_start is not consumed by that frame_start; it sets pending_step for the following frame.
- **Advance:**
  - pat_sel <= (pat_sel==NUM_PAT-1) ? 0 : pat_sel+1.
  - On the wrap to 0, chk_shift <= (chk_shift==CHK_MAX) ? CHK_MIN : chk_shift+1; otherwise chk_shift holds.
- **Colour table**, registered in the same edge as pat_sel:
  - 0: checker, fg FFF / bg 000.
  - 1: checker, fg F00 / bg 00F.
  - 2: solid, fg F00 / bg F00.
  - 3: solid, fg 0F0 / bg 0F0.
  - 4: colour bars, fg 000 / bg 000 (the pixel stage generates the bars).
  - Indices ≥5: fg 000 / bg 000.
- **Commit latency:** outputs change on the clk edge where frame_start=1 is sampled. cfg_update is high exactly the following cycle.
- **Simultaneous mode press and frame_start:**
  - The frame_start action of the *current* state executes.
  - The toggle takes effect on the same edge.
  - If the toggle enters AUTO, the clear wins over the increment.
- frame_start while rst=1 is ignored.

Test Plan:
1. Reset, then FRAMES_PER_PAT=3, NUM_PAT=5, 15 frame_start pulses -> pat_sel steps 0,1,2,3,4,0 every 3rd pulse; chk_shift goes 8 -> 5 at the wrap; cfg_update pulses 5 times, each exactly 1 cycle.
2. DEB_CYCLES=16: btn_mode high 10 cycles -> no toggle; btn_mode high 40 cycles -> auto_mode=0 exactly 18 cycles after the rising edge.
3. MANUAL: three next presses within one frame -> exactly one advance (pat_sel 0->1) at the next frame_start, none at the frame_start after that.
4. MANUAL: next press pulse coincident with frame_start -> pat_sel unchanged at that edge, advances at the following frame_start.
5. AUTO with frame counter at 2 of 3: mode press coincident with frame_start -> pattern advances, state=MANUAL; toggle back to AUTO -> counter=0, the next advance comes after 3 more frames.
6. Assert rst mid-sequence with pat_sel=3 and a step pending -> next cycle pat_sel=0, chk_shift=8, fg=FFF, bg=000, auto_mode=1; following frame_start does not step.

Source files
------------

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern sequencer for the 1920x1080 pixel generator.
// Picks pattern, checker size and colours; commits only on frame_start.

module vga_pattern_sched_deb #(
    parameter int DEB_CYCLES = 1485000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1_q;
    logic          s2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count how long the synchronised level differs from the stable level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_o  = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            cnt_d    = '0;
            stable_d = s2_q;
            press_o  = s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Two-flop synchroniser plus debounce state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module vga_pattern_sched #(
    parameter int FRAMES_PER_PAT = 60,
    parameter int NUM_PAT        = 5,
    parameter int DEB_CYCLES     = 1485000,
    parameter int CHK_MIN        = 5,
    parameter int CHK_MAX        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        btn_next,
    input  logic        btn_mode,
    output logic [2:0]  pat_sel,
    output logic [3:0]  chk_shift,
    output logic [11:0] fg_rgb,
    output logic [11:0] bg_rgb,
    output logic        auto_mode,
    output logic        cfg_update
);
    localparam int FW = $clog2(FRAMES_PER_PAT + 1);

    typedef enum logic [0:0] {
        ST_AUTO,
        ST_MANUAL
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [FW-1:0] frm_q;
    logic [FW-1:0] frm_d;
    logic          pend_q;
    logic          pend_d;
    logic [2:0]    pat_q;
    logic [2:0]    pat_d;
    logic [3:0]    chk_q;
    logic [3:0]    chk_d;
    logic [11:0]   fg_q;
    logic [11:0]   fg_d;
    logic [11:0]   bg_q;
    logic [11:0]   bg_d;
    logic          upd_q;
    logic          upd_d;
    logic          adv;
    logic          next_press;
    logic          mode_press;

    vga_pattern_sched_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_next),
        .press_o (next_press)
    );

    vga_pattern_sched_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_mode),
        .press_o (mode_press)
    );

    function automatic logic [23:0] colours(input logic [2:0] p);
        logic [23:0] c;
        case (p)
            3'd0:    c = {12'hFFF, 12'h000};
            3'd1:    c = {12'hF00, 12'h00F};
            3'd2:    c = {12'hF00, 12'hF00};
            3'd3:    c = {12'h0F0, 12'h0F0};
            default: c = {12'h000, 12'h000};
        endcase
        return c;
    endfunction

    // Mode FSM, frame counting and step scheduling.
    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        pend_d  = pend_q;
        adv     = 1'b0;
        case (state_q)
            ST_AUTO: begin
                if (frame_start) begin
                    if (frm_q == FW'(FRAMES_PER_PAT - 1)) begin
                        frm_d = '0;
                        adv   = 1'b1;
                    end else begin
                        frm_d = frm_q + FW'(1);
                    end
                end
                if (mode_press) begin
                    state_d = ST_MANUAL;
                end
            end
            default: begin
                if (frame_start && pend_q) begin
                    adv    = 1'b1;
                    pend_d = 1'b0;
                end
                // A press on the frame_start cycle belongs to the next frame.
                if (next_press) begin
                    pend_d = 1'b1;
                end
                if (mode_press) begin
                    state_d = ST_AUTO;
                    frm_d   = '0;
                    pend_d  = 1'b0;
                end
            end
        endcase
    end

    // Pattern advance with checker-size step on wrap, plus colour lookup.
    always_comb begin
        pat_d = pat_q;
        chk_d = chk_q;
        if (adv) begin
            if (pat_q == 3'(NUM_PAT - 1)) begin
                pat_d = '0;
                if (chk_q == 4'(CHK_MAX)) begin
                    chk_d = 4'(CHK_MIN);
                end else begin
                    chk_d = chk_q + 4'd1;
                end
            end else begin
                pat_d = pat_q + 3'd1;
            end
        end
        {fg_d, bg_d} = colours(pat_d);
        upd_d        = adv && ((pat_d != pat_q) || (chk_d != chk_q));
    end

    // State and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_AUTO;
            frm_q   <= '0;
            pend_q  <= 1'b0;
            pat_q   <= '0;
            chk_q   <= 4'(CHK_MAX);
            fg_q    <= 12'hFFF;
            bg_q    <= 12'h000;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frm_q   <= frm_d;
            pend_q  <= pend_d;
            pat_q   <= pat_d;
            chk_q   <= chk_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            upd_q   <= upd_d;
        end
    end

    assign pat_sel    = pat_q;
    assign chk_shift  = chk_q;
    assign fg_rgb     = fg_q;
    assign bg_rgb     = bg_q;
    assign auto_mode  = (state_q == ST_AUTO);
    assign cfg_update = upd_q;
endmodule

// File: tb/tb_vga_pattern_sched.sv
// Self-checking bench for vga_pattern_sched.
// Scoreboard of expected commits, popped on each cfg_update pulse.

module tb_vga_pattern_sched;
    localparam int FPP     = 3;
    localparam int NPAT    = 5;
    localparam int DEB     = 16;
    localparam int CMIN    = 5;
    localparam int CMAX    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        btn_next;
    logic        btn_mode;
    logic [2:0]  pat_sel;
    logic [3:0]  chk_shift;
    logic [11:0] fg_rgb;
    logic [11:0] bg_rgb;
    logic        auto_mode;
    logic        cfg_update;

    int checks = 0;
    int errors = 0;
    int n_upd  = 0;

    logic [30:0] sb_q[$];

    int m_pat;
    int m_chk;
    int m_frm;
    bit m_auto;
    bit m_pend;

    vga_pattern_sched #(
        .FRAMES_PER_PAT (FPP),
        .NUM_PAT        (NPAT),
        .DEB_CYCLES     (DEB),
        .CHK_MIN        (CMIN),
        .CHK_MAX        (CMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .btn_next    (btn_next),
        .btn_mode    (btn_mode),
        .pat_sel     (pat_sel),
        .chk_shift   (chk_shift),
        .fg_rgb      (fg_rgb),
        .bg_rgb      (bg_rgb),
        .auto_mode   (auto_mode),
        .cfg_update  (cfg_update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_col(input int p);
        case (p)
            0:       return {12'hFFF, 12'h000};
            1:       return {12'hF00, 12'h00F};
            2:       return {12'hF00, 12'hF00};
            3:       return {12'h0F0, 12'h0F0};
            default: return {12'h000, 12'h000};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_adv();
        if (m_pat == NPAT - 1) begin
            m_pat = 0;
            m_chk = (m_chk == CMAX) ? CMIN : m_chk + 1;
        end else begin
            m_pat = m_pat + 1;
        end
        sb_q.push_back({3'(m_pat), 4'(m_chk), exp_col(m_pat)});
    endtask

    task automatic model_frame();
        if (m_auto) begin
            if (m_frm == FPP - 1) begin
                m_frm = 0;
                model_adv();
            end else begin
                m_frm = m_frm + 1;
            end
        end else if (m_pend) begin
            m_pend = 1'b0;
            model_adv();
        end
    endtask

    task automatic model_mode();
        m_auto = !m_auto;
        if (m_auto) begin
            m_frm  = 0;
            m_pend = 1'b0;
        end
    endtask

    task automatic pulse_frame();
        model_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1;
        else         btn_next = 1'b1;
        repeat (40) tick();
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (25) tick();
        if (is_mode)      model_mode();
        else if (!m_auto) m_pend = 1'b1;
    endtask

    // Button press whose debounced pulse lands on the frame_start edge.
    task automatic press_on_frame(input bit is_mode);
        if (is_mode) btn_mode = 1'b1;
        else         btn_next = 1'b1;
        repeat (17) tick();
        model_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        if (is_mode)      model_mode();
        else if (!m_auto) m_pend = 1'b1;
        repeat (22) tick();
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (25) tick();
    endtask

    task automatic model_reset();
        m_pat  = 0;
        m_chk  = CMAX;
        m_frm  = 0;
        m_auto = 1'b1;
        m_pend = 1'b0;
    endtask

    // Every cfg_update cycle must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && cfg_update) begin
            n_upd++;
            if (sb_q.size() == 0) begin
                check("spurious_cfg_update", 32'd1, 32'd0);
            end else begin
                logic [30:0] e;
                e = sb_q.pop_front();
                check("sb_pat", 32'(pat_sel), 32'(e[30:28]));
                check("sb_chk", 32'(chk_shift), 32'(e[27:24]));
                check("sb_fg", 32'(fg_rgb), 32'(e[23:12]));
                check("sb_bg", 32'(bg_rgb), 32'(e[11:0]));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        btn_next    = 1'b0;
        btn_mode    = 1'b0;
        model_reset();
        frame_start = 1'b1;
        repeat (3) tick();
        frame_start = 1'b0;
        rst = 1'b0;
        tick();

        check("rst_pat", 32'(pat_sel), 32'd0);
        check("rst_chk", 32'(chk_shift), 32'(CMAX));
        check("rst_fg", 32'(fg_rgb), 32'hFFF);
        check("rst_bg", 32'(bg_rgb), 32'h000);
        check("rst_auto", 32'(auto_mode), 32'd1);
        check("rst_upd", 32'(cfg_update), 32'd0);

        // Auto sequencing through a full wrap.
        repeat (15) pulse_frame();
        check("auto_upd_count", 32'(n_upd), 32'd5);
        check("auto_pat_wrap", 32'(pat_sel), 32'd0);
        check("auto_chk_wrap", 32'(chk_shift), 32'(CMIN));

        // Short glitch is rejected, long press toggles after 18 cycles.
        btn_mode = 1'b1;
        repeat (10) tick();
        btn_mode = 1'b0;
        repeat (30) tick();
        check("glitch_auto", 32'(auto_mode), 32'd1);
        btn_mode = 1'b1;
        repeat (17) tick();
        check("mode_t17", 32'(auto_mode), 32'd1);
        tick();
        check("mode_t18", 32'(auto_mode), 32'd0);
        repeat (22) tick();
        btn_mode = 1'b0;
        repeat (25) tick();
        model_mode();
        check("manual_auto", 32'(auto_mode), 32'd0);

        // Three presses in one frame collapse to one step.
        repeat (3) press(1'b0);
        pulse_frame();
        check("multi_step", 32'(pat_sel), 32'd1);
        pulse_frame();
        check("multi_no2nd", 32'(pat_sel), 32'd1);

        // Press coincident with frame_start waits a frame.
        press_on_frame(1'b0);
        check("coinc_hold", 32'(pat_sel), 32'd1);
        pulse_frame();
        check("coinc_step", 32'(pat_sel), 32'd2);

        // Mode press on the counter's last frame: advance then MANUAL.
        press(1'b1);
        check("back_auto", 32'(auto_mode), 32'd1);
        repeat (2) pulse_frame();
        check("auto_cnt2", 32'(pat_sel), 32'd2);
        press_on_frame(1'b1);
        check("coinc_mode_pat", 32'(pat_sel), 32'd3);
        check("coinc_mode_man", 32'(auto_mode), 32'd0);
        press(1'b1);
        repeat (2) pulse_frame();
        check("auto_clr_hold", 32'(pat_sel), 32'd3);
        pulse_frame();
        check("auto_clr_step", 32'(pat_sel), 32'd4);

        // Walk to pattern 3 in manual, leave a step pending, then reset.
        press(1'b1);
        for (int i = 0; i < 4; i++) begin
            press(1'b0);
            pulse_frame();
        end
        check("pre_rst_pat", 32'(pat_sel), 32'd3);
        press(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mid_rst_pat", 32'(pat_sel), 32'd0);
        check("mid_rst_chk", 32'(chk_shift), 32'(CMAX));
        check("mid_rst_fg", 32'(fg_rgb), 32'hFFF);
        check("mid_rst_bg", 32'(bg_rgb), 32'h000);
        check("mid_rst_auto", 32'(auto_mode), 32'd1);
        pulse_frame();
        check("post_rst_nostep", 32'(pat_sel), 32'd0);

        repeat (4) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
